// File: rtl/cba_pkg.sv
// Shared types and constants for the sequential carry-bypass adder.
package cba_pkg;
    localparam int SLICE_W   = 4;
    localparam int CBA_CNT_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } cba_state_e;
endpackage

// File: rtl/pg_slice4.sv
// 4-bit propagate/generate slice with full lookahead carries and a bypass flag.
module pg_slice4
    import cba_pkg::*;
(
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b,
    input  logic               cin,
    output logic [SLICE_W-1:0] c,
    output logic [SLICE_W-1:0] p,
    output logic               bypass
);
    logic [SLICE_W-1:0] g;

    assign p = a ^ b;
    assign g = a & b;

    // c[i] is the carry out of bit i, flattened so no carry ripples through the slice
    assign c[0] = g[0] | (p[0] & cin);
    assign c[1] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    assign c[2] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & cin);
    assign c[3] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & cin);

    assign bypass = &p;
endmodule

// File: rtl/cba_seq_adder.sv
// Sequential carry-bypass adder: one 4-bit slice per clock behind valid/ready.
// Optional feature: define CBA_BYPASS_CNT_EN to add the saturating bypass_cnt output.
module cba_seq_adder
    import cba_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef CBA_BYPASS_CNT_EN
    ,
    output logic [CBA_CNT_W-1:0] bypass_cnt
`endif
);
    localparam int NSLICE = WIDTH / SLICE_W;
    localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    if ((WIDTH % SLICE_W) != 0 || WIDTH < SLICE_W) begin : g_bad_width
        $error("cba_seq_adder: WIDTH must be a multiple of 4 and >= 4");
    end

    cba_state_e         state, nstate;
    logic [IDX_W-1:0]   idx;
    logic               c;
    logic [WIDTH-1:0]   opa, opb;

    logic [SLICE_W-1:0] sa, sb, sc, sp, ssum;
    logic               sbyp, nc, last;

    assign sa   = opa[idx*SLICE_W +: SLICE_W];
    assign sb   = opb[idx*SLICE_W +: SLICE_W];
    assign last = (idx == IDX_W'(NSLICE - 1));

    pg_slice4 u_slice (
        .a      (sa),
        .b      (sb),
        .cin    (c),
        .c      (sc),
        .p      (sp),
        .bypass (sbyp)
    );

    assign ssum = sp ^ {sc[2:0], c};
    // Bypassed slices forward the incoming carry; arithmetically equal to sc[3]
    assign nc   = sbyp ? c : sc[3];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= nstate;
    end

    always_comb begin
        nstate    = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) nstate = RUN;
            end
            RUN:  if (last) nstate = DONE;
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) nstate = IDLE;
            end
            default: nstate = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            opa  <= '0;
            opb  <= '0;
            c    <= 1'b0;
            idx  <= '0;
            sum  <= '0;
            cout <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    opa <= a;
                    opb <= b;
                    c   <= cin;
                    idx <= '0;
                end
                RUN: begin
                    sum[idx*SLICE_W +: SLICE_W] <= ssum;
                    c   <= nc;
                    idx <= idx + 1'b1;
                    if (last) cout <= nc;
                end
                default: ;
            endcase
        end
    end

`ifdef CBA_BYPASS_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            bypass_cnt <= '0;
        else if (state == RUN && sbyp && bypass_cnt != '1)
            bypass_cnt <= bypass_cnt + 1'b1;
    end
`endif
endmodule

// File: tb/tb_cba_seq_adder.sv
// Self-checking bench for cba_seq_adder: directed cases plus randomized pairs vs a+b+cin.
module tb_cba_seq_adder;
    localparam int W = 16;
    localparam int N = W / 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid, in_ready, out_valid, out_ready, cin, cout;
    logic [W-1:0] a, b, sum;
`ifdef CBA_BYPASS_CNT_EN
    logic [15:0]  bypass_cnt;
`endif

    int total  = 0;
    int passed = 0;
    int exp_byp = 0;

    cba_seq_adder #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout)
`ifdef CBA_BYPASS_CNT_EN
        ,
        .bypass_cnt(bypass_cnt)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d so far", passed, total);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [W:0] ref_add(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic ci);
        return {1'b0, x} + {1'b0, y} + (W+1)'(ci);
    endfunction

    // Slices whose operand nibbles are bitwise complementary take the bypass path
    function automatic int ref_byp(input logic [W-1:0] x, input logic [W-1:0] y);
        int n = 0;
        for (int i = 0; i < N; i++)
            if ((((x >> (4*i)) ^ (y >> (4*i))) & W'(15)) == W'(15)) n++;
        return n;
    endfunction

    task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc,
                         input int bp, input string tag);
        int n, lat;
        logic [W:0] e;
        e = ref_add(ta, tb, tc);
        n = 0;
        while (!in_ready && n < 50) begin tick(); n++; end
        chk({tag, ".rdy"}, in_ready, 1);
        a = ta; b = tb; cin = tc; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
        exp_byp += ref_byp(ta, tb);
        lat = 0;
        while (!out_valid && lat < 40) begin tick(); lat++; end
        chk({tag, ".lat"}, lat, N);
        chk({tag, ".sum"}, sum, e[W-1:0]);
        chk({tag, ".cout"}, cout, e[W]);
`ifdef CBA_BYPASS_CNT_EN
        chk({tag, ".bcnt"}, bypass_cnt, exp_byp);
`endif
        for (int i = 0; i < bp; i++) begin
            tick();
            chk({tag, ".hold"}, {out_valid, in_ready, cout, sum}, {2'b10, e});
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({tag, ".idle"}, {out_valid, in_ready}, 2'b01);
    endtask

    initial begin
        int cnt;
        logic [W:0] e;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0;
        tick(); tick();
        chk("reset", {out_valid, in_ready, cout, sum}, {2'b01, 1'b0, W'(0)});
`ifdef CBA_BYPASS_CNT_EN
        chk("reset.bcnt", bypass_cnt, 0);
`endif
        rst = 1'b0;
        tick();

        do_op(16'h1234, 16'h4321, 1'b1, 0, "t1234");
        do_op(16'hFFFF, 16'h0001, 1'b0, 0, "tffff");
        do_op(16'h8000, 16'h8000, 1'b0, 0, "t8000");
        do_op(16'h0000, 16'h0000, 1'b1, 0, "tzero");
        do_op(16'h0F0F, 16'h00F0, 1'b0, 5, "bp");

        // Abort mid-operation with the slice index at 2
        a = 16'hABCD; b = 16'h1111; cin = 1'b1; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick(); tick();
        rst = 1'b1;
        #1;
        chk("abort", {out_valid, in_ready, cout, sum}, {2'b01, 1'b0, W'(0)});
`ifdef CBA_BYPASS_CNT_EN
        chk("abort.bcnt", bypass_cnt, 0);
`endif
        exp_byp = 0;
        #2 rst = 1'b0;
        tick();
        do_op(16'h00FF, 16'h0001, 1'b0, 0, "post");

        // in_valid and out_ready held high: one result every N+2 cycles
        a = 16'h1234; b = 16'h1111; cin = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        e = ref_add(16'h1234, 16'h1111, 1'b0);
        cnt = 0;
        repeat (3*(N+2)) begin
            tick();
            if (out_valid) begin
                cnt++;
                chk("b2b.sum", {cout, sum}, e);
            end
        end
        in_valid = 1'b0; out_ready = 1'b0;
        exp_byp += 3 * ref_byp(16'h1234, 16'h1111);
        chk("b2b.cnt", cnt, 3);
        tick();

        for (int i = 0; i < 300; i++) begin
            logic [W-1:0] ta, tb;
            logic tc;
            ta = W'($urandom); tb = W'($urandom); tc = 1'($urandom);
            if (i % 50 == 7) begin ta = '1; tb = '0; tc = 1'b1; end
            if (i % 50 == 23) tb = ~ta;
            do_op(ta, tb, tc, int'($urandom_range(2, 0)), "rnd");
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/cba_seq_adder.md
# cba_seq_adder

Sequential carry-bypass adder: accepts a WIDTH-bit operand pair and produces the sum one 4-bit slice per clock. Each cycle it drives a single 4-bit propagate/generate slice and keeps the inter-slice carry in a register. When all four propagate bits of a slice are set, the carry-in bypasses that slice. This is the stage directly downstream of the 4-bit P/G slice: it consumes the slice's carry and propagate outputs and assembles the full-width result behind valid/ready handshakes.

## Interface
Parameters:
- WIDTH, 16, operand/sum width; must be a multiple of 4 and ≥ 4 (elaboration error otherwise)
- NSLICE, WIDTH/4, derived slice count; not overridable

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset; asynchronous, active-high
- in_valid  in  1  operand pair valid
- in_ready  out  1  block can accept operands
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- cin  in  1  carry-in to slice 0
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- sum  out  WIDTH  registered sum
- cout  out  1  carry-out of top slice
- bypass_cnt  out  16  bypassed-slice counter (only with CBA_BYPASS_CNT_EN)

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE: in_ready=1. On in_valid&&in_ready, latch a, b, cin into the operand registers, clear slice index idx=0, load carry register c=cin, and go to RUN.
- RUN: in_ready=0, out_valid=0. Slice i = idx holds a[4i+3:4i] and b[4i+3:4i]:
  - p = a^b, g = a&b;
  - lookahead carries c0..c3 computed from c;
  - sum slice = p ^ {c2,c1,c0,c};
  - next c = (&p) ? c : c3 (bypass path; the value is arithmetically identical).
  - Write the sum slice into the sum register and increment idx.
  - After slice NSLICE-1: cout=next c, go to DONE.
- DONE: out_valid=1, in_ready=0. sum and cout hold stable until out_valid&&out_ready, then go to IDLE.
- No same-cycle re-accept: the DONE→IDLE edge does not also accept new operands.
- Operand inputs are ignored outside IDLE. Input changes during RUN have no effect.
- Arithmetic: {cout,sum} = a + b + cin, modulo 2^(WIDTH+1), unsigned.

## Timing
- Reset values:
  - state=IDLE, in_ready=1, out_valid=0, sum=0, cout=0, idx=0, c=0, bypass_cnt=0.
- Latency: acceptance at edge k → out_valid high after edge k+NSLICE.
- Throughput: one operation per NSLICE+2 cycles with out_ready held high.
- Backpressure: while out_ready=0 in DONE, all outputs hold indefinitely.
- Reset mid-RUN or mid-DONE aborts the operation immediately (asynchronous). Outputs return to reset values and no partial result is presented.
- in_valid may drop before acceptance without penalty. in_valid held high across DONE is accepted on the first IDLE cycle.

## Configuration
- CBA_BYPASS_CNT_EN defined:
  - bypass_cnt port exists;
  - increments by 1 on each RUN cycle whose slice has &p==1;
  - saturates at 0xFFFF;
  - cleared only by rst.
- Undefined: the port and counter logic are absent. All other behaviour is identical.

## Structure
- Shared package cba_pkg:
  - FSM state enum (IDLE/RUN/DONE);
  - SLICE_W=4 constant;
  - bypass counter width CBA_CNT_W=16.
- One sub-module, pg_slice4:
  - purely combinational;
  - inputs: 4-bit a, 4-bit b, cin;
  - outputs: 4-bit carries, 4-bit propagate, bypass flag (&p).
  - The top level instantiates it once and muxes the slice operands by idx.

## Test plan
- WIDTH=16, a=0x1234, b=0x4321, cin=1 → sum=0x5556, cout=0, out_valid 4 cycles after acceptance.
- a=0xFFFF, b=0x0001, cin=0 → sum=0x0000, cout=1; with CBA_BYPASS_CNT_EN, bypass_cnt increases by 3 (slices 1–3).
- a=0x8000, b=0x8000, cin=0 → sum=0x0000, cout=1; then a=0, b=0, cin=1 → sum=0x0001, cout=0.
- Backpressure: hold out_ready=0 for 5 cycles in DONE → sum/cout stable, in_ready=0, no new accept; release → IDLE next cycle, in_ready=1.
- Reset asserted at RUN idx=2 → next sample shows out_valid=0, sum=0, in_ready=1. A following add of 0x00FF+0x0001 → 0x0100.
- Random regression, 10k pairs for WIDTH=4, 16 and 32, against a golden model of a+b+cin, including back-to-back in_valid.
